// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_port_arbiter : shares one data-memory port between core and debug ports
// Rev 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ready,
    output logic          core_done,
    output logic          core_err,
    output logic [DW-1:0] core_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ready,
    output logic          dbg_done,
    output logic          dbg_err,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [2:0] LAT_LIM    = 3'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t        state;
    logic          own_dbg;
    logic          acc_we;
    logic [AW-3:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic [2:0]    lat_cnt;
    logic [3:0]    starve_cnt;
    logic [DW-1:0] core_rdata_q;
    logic [DW-1:0] dbg_rdata_q;

    logic          idle;
    logic          starved;
    logic          core_grant;
    logic          dbg_grant;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          rd_done;
    logic          st_done;
    logic          err_done;
    logic          any_done;

    // rst gates ready so nothing is offered while reset is held
    assign idle       = rst && (state == IDLE);
    assign starved    = (starve_cnt == STARVE_LIM);
    assign core_grant = idle && core_req && (!dbg_req || !starved);
    assign dbg_grant  = idle && dbg_req && (!core_req || starved);

    assign sel_we    = dbg_grant ? dbg_we    : core_we;
    assign sel_addr  = dbg_grant ? dbg_addr  : core_addr;
    assign sel_wdata = dbg_grant ? dbg_wdata : core_wdata;

    assign rd_done  = (state == WAIT_RD) && (lat_cnt == LAT_LIM);
    assign st_done  = (state == ISSUE) && acc_we;
    assign err_done = (state == ERR);
    assign any_done = rd_done || st_done || err_done;

    assign core_ready = core_grant;
    assign dbg_ready  = dbg_grant;
    assign core_done  = any_done && !own_dbg;
    assign dbg_done   = any_done && own_dbg;
    assign core_err   = err_done && !own_dbg;
    assign dbg_err    = err_done && own_dbg;

    // Read data bypasses the holding register in the done cycle itself
    assign core_rdata = (rd_done && !own_dbg) ? mem_rdata : core_rdata_q;
    assign dbg_rdata  = (rd_done && own_dbg)  ? mem_rdata : dbg_rdata_q;

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en && acc_we;
    assign mem_addr  = acc_addr;
    assign mem_wdata = acc_wdata;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            own_dbg      <= 1'b0;
            acc_we       <= 1'b0;
            acc_addr     <= '0;
            acc_wdata    <= '0;
            lat_cnt      <= 3'd0;
            starve_cnt   <= 4'd0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            if (!dbg_req || dbg_grant) begin
                starve_cnt <= 4'd0;
            end else if (core_grant && !starved) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (core_grant || dbg_grant) begin
                        own_dbg   <= dbg_grant;
                        acc_we    <= sel_we;
                        acc_addr  <= sel_addr[AW-1:2];
                        acc_wdata <= sel_wdata;
                        state     <= (sel_addr[1:0] != 2'b00) ? ERR : ISSUE;
                    end
                end
                ISSUE: begin
                    if (acc_we) begin
                        state <= IDLE;
                    end else begin
                        state   <= WAIT_RD;
                        lat_cnt <= 3'd1;
                    end
                end
                WAIT_RD: begin
                    if (lat_cnt == LAT_LIM) begin
                        if (own_dbg) begin
                            dbg_rdata_q <= mem_rdata;
                        end else begin
                            core_rdata_q <= mem_rdata;
                        end
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_port_arbiter : scoreboard bench for dmem_port_arbiter
// Rev 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic        core_ready, core_done, core_err, dbg_ready, dbg_done, dbg_err;
    logic [31:0] core_rdata, dbg_rdata;
    logic        mem_en, mem_we, busy;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ready(core_ready), .core_done(core_done),
        .core_err(core_err), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready), .dbg_done(dbg_done),
        .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory model with a fixed read pipeline of LAT cycles
    logic [31:0] mem [0:255];
    logic [31:0] rd_pipe [0:LAT-1];
    logic        pl_en;
    logic [7:0]  pl_a;
    logic [31:0] pl_d;

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) rd_pipe[0] <= mem[mem_addr[7:0]];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          d;
        bit          we;
        bit          err;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    typedef struct {
        bit          we;
        logic [29:0] a;
        logic [31:0] wd;
        int          at;
    } mexp_t;

    exp_t  sb_q[$];
    mexp_t mem_q[$];
    bit    grant_q[$];
    bit    busy_q[$];
    bit    rec = 1'b0;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        fails++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Present one request; on acceptance push the expected responses
    task automatic issue(input bit d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rexp, input bit keep);
        bit err;
        bit got;
        err = (addr[1:0] != 2'b00);
        got = 1'b0;
        if (d) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        end else begin
            core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (d ? dbg_ready : core_ready) begin
                got = 1'b1;
                sb_q.push_back('{d: d, we: we, err: err, rdata: rexp, acc: cyc});
                if (!err) mem_q.push_back('{we: we, a: addr[31:2], wd: wd, at: cyc + 1});
                grant_q.push_back(d);
                @(posedge clk);
                #1;
            end
        end
        if (!got) fail_now("accept_timeout");
        if (!keep || !got) begin
            if (d) dbg_req = 1'b0;
            else core_req = 1'b0;
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] dv);
        pl_en = 1'b1; pl_a = a; pl_d = dv;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctrl"}, 32'({core_ready, dbg_ready, core_done, dbg_done, core_err,
                                 dbg_err, mem_en, mem_we, busy}), 32'd0);
        chk({tag, "_rdata"}, core_rdata | dbg_rdata, 32'd0);
        chk({tag, "_maddr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mwdata"}, mem_wdata, 32'd0);
    endtask

    // Monitor: completion pulses and memory strobes against the queues
    always @(negedge clk) begin : monitor
        exp_t  e;
        mexp_t m;
        if (core_done || dbg_done) begin
            if (core_done && dbg_done) fail_now("done_both");
            if (sb_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                e = sb_q.pop_front();
                chk("done_owner", 32'(dbg_done), 32'(e.d));
                chk("done_err", 32'(e.d ? dbg_err : core_err), 32'(e.err));
                chk("done_latency", 32'(cyc - e.acc), (e.err || e.we) ? 32'd1 : 32'(1 + LAT));
                if (!e.we && !e.err) chk("load_rdata", e.d ? dbg_rdata : core_rdata, e.rdata);
            end
        end
        if (mem_en) begin
            if (mem_q.size() == 0) begin
                fail_now("unexpected_mem_en");
            end else begin
                m = mem_q.pop_front();
                chk("mem_we", 32'(mem_we), 32'(m.we));
                chk("mem_addr", 32'(mem_addr), 32'(m.a));
                if (m.we) chk("mem_wdata", mem_wdata, m.wd);
                chk("mem_cycle", 32'(cyc), 32'(m.at));
            end
        end
        if (rec) busy_q.push_back(busy);
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit exp_g [10];
        bit exp_b [7];
        exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        exp_b = '{0, 1, 0, 1, 1, 1, 0};

        rst = 1'b0;
        pl_en = 1'b0; pl_a = '0; pl_d = '0;
        core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        core_req = 1'b1;
        dbg_req  = 1'b1;
        @(negedge clk);
        chk_reset("reset0");
        core_req = 1'b0;
        dbg_req  = 1'b0;
        #12;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: core store
        issue(0, 1, 32'd100, 32'd25, 32'd0, 0);
        idle_cycles(3);

        // 2: core load of a preloaded word
        preload(8'd25, 32'hDEADBEEF);
        preload(8'd24, 32'h11111111);
        issue(0, 0, 32'd100, 32'd0, 32'hDEADBEEF, 0);
        idle_cycles(6);

        // 3: both ports held requesting
        grant_q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue(0, 1, 32'h40 + 32'(4 * i), 32'h100 + 32'(i), 32'd0, i < 7);
            end
            begin
                for (int j = 0; j < 2; j++)
                    issue(1, 0, 32'd100, 32'd0, 32'hDEADBEEF, j < 1);
            end
        join
        idle_cycles(6);
        chk("grant_count", 32'(grant_q.size()), 32'd10);
        for (int k = 0; k < 10 && k < grant_q.size(); k++)
            chk($sformatf("grant_%0d", k), 32'(grant_q[k]), 32'(exp_g[k]));

        // 4: misaligned store
        issue(0, 1, 32'h62, 32'hABCD, 32'd0, 0);
        idle_cycles(3);
        chk("mem_unchanged", mem[24], 32'h11111111);

        // 5: reset during WAIT_RD, then a debug load
        issue(0, 0, 32'd100, 32'd0, 32'hDEADBEEF, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk_reset("reset_mid");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 0, 32'd100, 32'd0, 32'hDEADBEEF, 0);
        idle_cycles(6);

        // 6: debug store then core load of the same word
        rec = 1'b1;
        issue(1, 1, 32'd8, 32'd7, 32'd0, 0);
        issue(0, 0, 32'd8, 32'd0, 32'd7, 0);
        idle_cycles(4);
        rec = 1'b0;
        chk("busy_count", 32'(busy_q.size()), 32'd7);
        for (int k = 0; k < 7 && k < busy_q.size(); k++)
            chk($sformatf("busy_%0d", k), 32'(busy_q[k]), 32'(exp_b[k]));
        idle_cycles(3);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("memq_empty", 32'(mem_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
